// File: rtl/mem_responder.sv
// Word-wide memory responder for a multicycle CPU memory port.
// Ports: clk/reset in; req_i, memwrite_i, adr_i, writedata_i in;
//        memdata_o, ready_o, err_o, busy_o out.
module mem_responder #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_i,
  input  logic             memwrite_i,
  input  logic [WIDTH-1:0] adr_i,
  input  logic [WIDTH-1:0] writedata_i,
  output logic [WIDTH-1:0] memdata_o,
  output logic             ready_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_LOAD =
    (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    bad_q, bad_d;
  logic [WIDTH-1:0]        memdata_q;

  logic [WIDTH-1:0]        ram [DEPTH];

  logic                    in_bad;
  logic [DEPTH_LOG2-1:0]   in_idx;

  // Commit port: fed straight from the inputs when a zero-latency
  // access commits on its capture edge, else from captured regs.
  logic                    commit;
  logic [DEPTH_LOG2-1:0]   c_idx;
  logic                    c_we;
  logic [WIDTH-1:0]        c_wd;

  assign in_idx = adr_i[DEPTH_LOG2+1:2];
  assign in_bad = (adr_i[1:0] != 2'b00) ||
                  (adr_i[WIDTH-1:DEPTH_LOG2+2] != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    bad_d   = bad_q;
    commit  = 1'b0;
    c_idx   = idx_q;
    c_we    = we_q;
    c_wd    = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          idx_d   = in_idx;
          wdata_d = writedata_i;
          we_d    = memwrite_i;
          bad_d   = in_bad;
          if (in_bad) begin
            state_d = S_RESP;
          end else if (LATENCY == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
            c_idx   = in_idx;
            c_we    = memwrite_i;
            c_wd    = writedata_i;
          end else begin
            cnt_d   = LAT_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Bad accesses bypass WAIT, so anything here commits.
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      bad_q     <= 1'b0;
      memdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
      if (commit && !c_we) begin
        memdata_q <= ram[c_idx];
      end
    end
  end

  // RAM is not cleared by reset; a reset edge cancels a pending write.
  always_ff @(posedge clk) begin
    if (!reset && commit && c_we) begin
      ram[c_idx] <= c_wd;
    end
  end

  assign memdata_o = memdata_q;
  assign ready_o   = (state_q == S_RESP);
  assign err_o     = (state_q == S_RESP) && bad_q;
  assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level model, random and directed
// stimulus, plus a zero-latency instance for back-to-back access.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wd = '0;
  logic [31:0] memdata;
  logic        ready, err, busy;

  logic        req0 = 1'b0;
  logic        we0 = 1'b0;
  logic [31:0] adr0 = '0;
  logic [31:0] wd0 = '0;
  logic [31:0] md0;
  logic        rdy0, err0, busy0;

  always #5 clk = ~clk;

  mem_responder #(.WIDTH(32), .DEPTH_LOG2(8), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req_i(req), .memwrite_i(we),
    .adr_i(adr), .writedata_i(wd), .memdata_o(memdata),
    .ready_o(ready), .err_o(err), .busy_o(busy)
  );

  mem_responder #(.WIDTH(32), .DEPTH_LOG2(8), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_i(req0), .memwrite_i(we0),
    .adr_i(adr0), .writedata_i(wd0), .memdata_o(md0),
    .ready_o(rdy0), .err_o(err0), .busy_o(busy0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted access finishes at edge
  // accept + LATENCY (accept edge for bad ones); idle one edge later.
  logic [31:0] mmem [256];
  bit          act_m = 0;
  longint      e_cnt = 0;
  longint      rdy_e = 0;
  bit          mbad, mwe;
  int          midx;
  logic [31:0] mwd;
  logic        e_ready, e_err, e_busy;
  logic [31:0] e_md;
  bit          chk_en = 0;

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = '0;
    forever begin
      @(posedge clk);
      e_cnt++;
      if (reset) begin
        act_m   = 0;
        e_ready = 0;
        e_err   = 0;
        e_busy  = 0;
        e_md    = '0;
        chk_en  = 1;
      end else begin
        if (act_m && e_cnt == rdy_e + 1) begin
          act_m = 0;
        end else if (!act_m && req) begin
          act_m = 1;
          mwe   = we;
          mwd   = wd;
          midx  = int'((adr >> 2) % 256);
          mbad  = (adr % 4 != 0) || (adr >= 32'd1024);
          rdy_e = e_cnt + (mbad ? 0 : LAT);
        end
        e_busy  = act_m;
        e_ready = act_m && (e_cnt == rdy_e);
        e_err   = e_ready && mbad;
        if (e_ready && !mbad) begin
          if (mwe) mmem[midx] = mwd;
          else     e_md = mmem[midx];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("ready", 32'(ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(e_busy));
        if (e_ready) chk("err", 32'(err), 32'(e_err));
        chk("memdata", memdata, e_md);
      end
    end
  end

  // n = edges from the sampling edge (counted as 1) to ready; -1 on timeout.
  task automatic access(input bit w, input logic [31:0] a,
                        input logic [31:0] d, output int n,
                        output logic e_o, output logic [31:0] md);
    @(negedge clk);
    req = 1'b1; we = w; adr = a; wd = d;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); adr = $urandom; wd = $urandom;
    while (!ready && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    e_o = err;
    md  = memdata;
    if (!ready) n = -1;
    @(negedge clk);
  endtask

  int          n, pulses, r;
  logic        e1;
  logic [31:0] md1;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_memdata", memdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) access(1, 32'(i * 4), 32'd0, n, e1, md1);

    access(1, 32'h10, 32'hDEADBEEF, n, e1, md1);
    chk("t1_wr_lat", 32'(n), 32'd3);
    chk("t1_wr_err", 32'(e1), 32'd0);
    access(0, 32'h10, 32'h0, n, e1, md1);
    chk("t1_rd_lat", 32'(n), 32'd3);
    chk("t1_rd_data", md1, 32'hDEADBEEF);

    access(0, 32'h11, 32'h0, n, e1, md1);
    chk("t2_lat", 32'(n), 32'd1);
    chk("t2_err", 32'(e1), 32'd1);
    chk("t2_md_kept", md1, 32'hDEADBEEF);
    access(0, 32'h10, 32'h0, n, e1, md1);
    chk("t2_reread", md1, 32'hDEADBEEF);

    access(1, 32'h0, 32'hCAFEF00D, n, e1, md1);
    access(1, 32'h400, 32'h12345678, n, e1, md1);
    chk("t3_lat", 32'(n), 32'd1);
    chk("t3_err", 32'(e1), 32'd1);
    access(0, 32'h0, 32'h0, n, e1, md1);
    chk("t3_noalias", md1, 32'hCAFEF00D);

    @(negedge clk);
    req = 1'b1; we = 1'b1; adr = 32'h30; wd = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    pulses = 0;
    if (ready) pulses++;
    adr = 32'h34; wd = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ready) pulses++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("t4_pulses", 32'(pulses), 32'd1);
    access(0, 32'h30, 32'h0, n, e1, md1);
    chk("t4_first", md1, 32'h11111111);
    access(0, 32'h34, 32'h0, n, e1, md1);
    chk("t4_second", md1, 32'h0);

    @(negedge clk);
    req = 1'b1; we = 1'b1; adr = 32'h20; wd = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("t5_busy_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("t5_busy_rst", 32'(busy), 32'd0);
    access(0, 32'h20, 32'h0, n, e1, md1);
    chk("t5_old", md1, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      req   = 1'($urandom);
      we    = 1'($urandom);
      wd    = $urandom;
      r     = $urandom_range(0, 9);
      if (r < 6)      adr = 32'($urandom_range(0, 15) * 4);
      else if (r < 8) adr = 32'($urandom_range(0, 255) * 4);
      else if (r < 9) adr = 32'($urandom_range(0, 1023)) | 32'd1;
      else            adr = {1'b1, 31'($urandom)} & ~32'd3;
    end
    @(negedge clk);
    reset = 1'b0;
    req   = 1'b0;
    repeat (8) @(negedge clk);

    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; adr0 = 32'h8; wd0 = 32'h1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t6_ready", 32'(rdy0), 32'((k % 2) == 0));
      if (k >= 2 && (k % 2) == 0) begin
        chk("t6_data", md0, 32'h1);
        chk("t6_err", 32'(err0), 32'd0);
      end
      we0 = 1'b0;
    end
    req0 = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
